// File: rtl/map_mem_arbiter.sv
// Round-robin arbiter sharing the single-port map tile RAM between NUM_REQ requesters.
// Latency: grant and RAM issue one cycle after req is sampled; read data one cycle after issue.
// Backpressure: requesters hold req until their one-cycle gnt pulse; out-of-range accesses never stall.
module map_mem_arbiter #(
    parameter int NUM_ROW       = 11,
    parameter int NUM_COL       = 19,
    parameter int MAP_MEM_WIDTH = 2,
    parameter int NUM_REQ       = 4,
    localparam int DEPTH        = NUM_ROW * NUM_COL,
    localparam int ADDR_WIDTH   = $clog2(DEPTH)
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ-1:0]               we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_i,
    input  logic [NUM_REQ*MAP_MEM_WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [NUM_REQ-1:0]               rvalid_o,
    output logic [MAP_MEM_WIDTH-1:0]         rdata_o,
    output logic                             oor_err_o,
    output logic                             mem_en_o,
    output logic                             mem_we_o,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    output logic [MAP_MEM_WIDTH-1:0]         mem_wdata_o,
    input  logic [MAP_MEM_WIDTH-1:0]         mem_rdata_i
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic                     started_q;
    logic [NUM_REQ-1:0]       gnt_q, gnt_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic                     iss_we_q, iss_we_d;
    logic [ADDR_WIDTH-1:0]    iss_addr_q, iss_addr_d;
    logic [MAP_MEM_WIDTH-1:0] iss_wdata_q, iss_wdata_d;
    logic [NUM_REQ-1:0]       rvalid_q, rvalid_d;
    logic                     rd_oor_q, rd_oor_d;

    logic [NUM_REQ-1:0]       elig;
    logic                     found;
    logic [PTR_W-1:0]         win;
    logic                     sel_we;
    logic [ADDR_WIDTH-1:0]    sel_addr;
    logic [MAP_MEM_WIDTH-1:0] sel_wdata;
    logic                     iss_act;
    logic                     in_range;

    // A requester already holding gnt is masked so its still-high req is not granted twice.
    assign elig = req_i & ~gnt_q;

    always_comb begin
        int idx;
        found     = 1'b0;
        win       = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && elig[idx]) begin
                found     = 1'b1;
                win       = PTR_W'(idx);
                sel_we    = we_i[idx];
                sel_addr  = addr_i[idx*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata_i[idx*MAP_MEM_WIDTH +: MAP_MEM_WIDTH];
            end
        end
    end

    // Arbitration is held off for the first edge after reset release.
    always_comb begin
        gnt_d       = '0;
        ptr_d       = ptr_q;
        iss_we_d    = iss_we_q;
        iss_addr_d  = iss_addr_q;
        iss_wdata_d = iss_wdata_q;
        if (started_q && found) begin
            gnt_d       = NUM_REQ'(1) << win;
            ptr_d       = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            iss_we_d    = sel_we;
            iss_addr_d  = sel_addr;
            iss_wdata_d = sel_wdata;
        end
    end

    assign iss_act  = |gnt_q;
    assign in_range = {1'b0, iss_addr_q} < DEPTH_W;

    assign mem_en_o    = iss_act && in_range;
    assign mem_we_o    = mem_en_o && iss_we_q;
    assign mem_addr_o  = iss_addr_q;
    assign mem_wdata_o = iss_wdata_q;
    assign oor_err_o   = iss_act && !in_range;

    // Out-of-range reads still return (as zero) so the requester never waits forever.
    always_comb begin
        rvalid_d = iss_we_q ? '0 : gnt_q;
        rd_oor_d = !in_range;
    end

    assign gnt_o    = gnt_q;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = (|rvalid_q && !rd_oor_q) ? mem_rdata_i : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            started_q   <= 1'b0;
            gnt_q       <= '0;
            ptr_q       <= '0;
            iss_we_q    <= 1'b0;
            iss_addr_q  <= '0;
            iss_wdata_q <= '0;
            rvalid_q    <= '0;
            rd_oor_q    <= 1'b0;
        end else begin
            started_q   <= 1'b1;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            iss_we_q    <= iss_we_d;
            iss_addr_q  <= iss_addr_d;
            iss_wdata_q <= iss_wdata_d;
            rvalid_q    <= rvalid_d;
            rd_oor_q    <= rd_oor_d;
        end
    end

endmodule

// File: doc/map_mem_arbiter.md
# map_mem_arbiter

Round-robin arbiter that shares the single-port map tile RAM (NUM_ROW x NUM_COL entries, MAP_MEM_WIDTH bits each) between NUM_REQ requesters: player collision reads, bomb placement writes and explosion clears. It sits between the game-logic blocks and the map BRAM. It issues at most one memory access per cycle and returns read data to the issuing requester with a fixed latency. Out-of-range addresses are rejected without touching the RAM.

## Interface
- NUM_ROW, 11, map rows
- NUM_COL, 19, map columns
- MAP_MEM_WIDTH, 2, bits per tile entry
- NUM_REQ, 4, number of requesters (>=2)
- DEPTH (local), NUM_ROW*NUM_COL = 209
- ADDR_WIDTH (local), $clog2(DEPTH) = 8
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- req  in  NUM_REQ  request per requester; held until gnt
- we  in  NUM_REQ  1 = write, 0 = read; stable while req high
- addr  in  NUM_REQ*ADDR_WIDTH  flattened per-requester tile address, slice i = requester i
- wdata  in  NUM_REQ*MAP_MEM_WIDTH  flattened per-requester write data
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
- rvalid  out  NUM_REQ  one-hot, one-cycle read-data-valid pulse
- rdata  out  MAP_MEM_WIDTH  shared read data, meaningful only while rvalid != 0
- oor_err  out  1  one-cycle pulse: granted access had addr >= DEPTH
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  MAP_MEM_WIDTH  RAM write data
- mem_rdata  in  MAP_MEM_WIDTH  RAM read data, valid 1 cycle after mem_en && !mem_we

## Operation
- Eligible(i) = req[i] && !gnt[i]; a requester whose gnt is currently high is masked for that cycle's arbitration (prevents double grant on the held req).
- Round-robin pointer ptr (log2 NUM_REQ bits): search eligible requesters starting at ptr, wrapping modulo NUM_REQ; first found = winner w.
- On a winner, next edge: gnt[w]=1, ptr <= (w+1) mod NUM_REQ; latch we[w], addr slice w, wdata slice w into the issue registers.
- No eligible requester: gnt=0, ptr unchanged, mem_en=0.
- Issue stage (same cycle as gnt): if latched addr < DEPTH, mem_en=1, mem_we=latched we, mem_addr/mem_wdata = latched values; else mem_en=0, mem_we=0, oor_err=1.
- Read return: one cycle after an in-range read issue, rvalid[w]=1 and rdata = mem_rdata (combinational pass-through).
- Out-of-range read: rvalid[w]=1 one cycle after grant with rdata = 0 (requester never stalls); out-of-range write: dropped.
- Writes produce no rvalid.
- Read-after-write to the same address on consecutive grants returns the new data (RAM is write-first or the write has completed by the read's issue; arbiter adds no forwarding).
- Fairness: a held request is granted within NUM_REQ cycles of becoming eligible.

## Timing
- Cycle N: req sampled. Cycle N+1: gnt, mem_en/addr/we/wdata (registered). Cycle N+2: rvalid, rdata for reads.
- Throughput: one access per cycle across requesters; same requester at most every other cycle while req is held.
- Requester deasserts req or changes we/addr/wdata only in the cycle gnt is seen; a new request may be presented in that same cycle (sampled next edge).
- Reset (rst low, asynchronous): gnt=0, rvalid=0, oor_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, ptr=0, issue registers cleared. A read issued in the cycle before reset assertion produces no rvalid. First grant possible on the second rising edge after rst goes high.

## Test plan
- Reset: drive rst=0 mid-stream with req=4'b1111 -> all outputs 0 immediately; release, first gnt after 2 edges to requester 0.
- Single read: req[0], we=0, addr=10, RAM entry 10 = 2'b10 -> gnt=4'b0001 at N+1, mem_addr=10, mem_en=1; rvalid=4'b0001, rdata=2'b10 at N+2.
- Write then read: req[2] write addr=40 wdata=2'b11, then req[1] read addr=40 -> read returns 2'b11.
- Contention: req=4'b1111 held, each requester dropping req after its gnt -> grants 0001,0010,0100,1000 on consecutive cycles; next burst starts at ptr=0.
- Fairness with hog: req[0] re-asserted continuously, req[3] held -> req[3] granted within 4 cycles; gnt[0] never on two consecutive cycles.
- Bounds: read addr=208 -> mem_en=1; read addr=209 -> mem_en=0, oor_err=1, rvalid next cycle with rdata=0; write addr=255 -> no RAM write, oor_err=1.
